port_bus_sequencer: RTL and testbench

- Drives one bidirectional cartridge/link port on behalf of a core. It is the controlling end of the port bundle (direction select, outbound data, inbound data).
- Converts valid/ready read and write requests into timed port cycles: turnaround, setup, strobe and hold.
- Returns read data over a valid/ready response channel.
- Sits between core logic and the top-level tri-state port binding. Its outputs feed the port's direction, to-port and from-port signals directly.

---
 rtl/port_bus_sequencer.sv | 165 ++++++++++++++++
 tb/tb_port_bus_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/port_bus_sequencer.sv
// Controlling end of a bidirectional port: turns valid/ready requests into
// turnaround / setup / strobe / hold cycles and returns read data on a response channel.
module port_bus_sequencer #(
  parameter int WIDTH         = 8,
  parameter int TURN_CYCLES   = 2,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             dir_to_port,
  output logic [WIDTH-1:0] to_port,
  input  logic [WIDTH-1:0] from_port,
  output logic             port_strobe
);

  if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1) begin : g_bad_params
    $error("port_bus_sequencer: SETUP_CYCLES and STROBE_CYCLES must be >= 1");
  end

  localparam int MAX_TS = (TURN_CYCLES > SETUP_CYCLES) ? TURN_CYCLES : SETUP_CYCLES;
  localparam int MAX_SH = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_TS > MAX_SH) ? MAX_TS : MAX_SH;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef logic [CW-1:0] cnt_t;
  // Counter is loaded with N-1 on entry and the state is left when it reaches zero.
  localparam cnt_t TURN_LD   = cnt_t'(TURN_CYCLES - 1);
  localparam cnt_t SETUP_LD  = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t STROBE_LD = cnt_t'(STROBE_CYCLES - 1);
  localparam cnt_t HOLD_LD   = cnt_t'(HOLD_CYCLES - 1);
  localparam bit   HAS_TURN  = (TURN_CYCLES > 0);
  localparam bit   HAS_HOLD  = (HOLD_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_TURN, S_SETUP, S_STROBE, S_HOLD, S_RESP
  } state_t;

  state_t           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] to_q, to_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] rsp_q, rsp_d;
  logic             txn_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      to_q    <= '0;
      last_q  <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      to_q    <= to_d;
      last_q  <= last_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    data_d   = data_q;
    dir_d    = dir_q;
    to_d     = to_q;
    last_d   = last_q;
    rsp_d    = rsp_q;
    txn_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d   = req_write;
          data_d = req_data;
          if (HAS_TURN && (req_write != last_q)) begin
            state_d = S_TURN;
            cnt_d   = TURN_LD;
            dir_d   = 1'b0;
            to_d    = '0;
          end else begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
            dir_d   = req_write;
            to_d    = req_write ? req_data : '0;
          end
        end
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          dir_d   = wr_q;
          to_d    = wr_q ? data_q : '0;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          // Only the value present in the final strobe cycle is kept.
          if (!wr_q) rsp_d = from_port;
          if (HAS_HOLD) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            txn_done = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) txn_done = 1'b1;
        else             cnt_d = cnt_q - cnt_t'(1);
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (txn_done) begin
      last_d  = wr_q;
      state_d = wr_q ? S_IDLE : S_RESP;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign port_strobe = (state_q == S_STROBE);
  assign dir_to_port = dir_q;
  assign to_port     = to_q;
  assign rsp_data    = rsp_q;

endmodule

// File: tb/tb_port_bus_sequencer.sv
// Directed bench for port_bus_sequencer with default timing (turn 2, setup 2, strobe 4, hold 1).
module tb_port_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       busy, dir_to_port, port_strobe;
  logic [7:0] to_port, from_port;

  int n_cmp = 0;
  int n_err = 0;

  port_bus_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .dir_to_port(dir_to_port), .to_port(to_port),
    .from_port(from_port), .port_strobe(port_strobe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic dir, input logic [7:0] tp,
                              input logic stb, input logic bsy);
    check_eq({tag, "/dir"},    32'(dir_to_port), 32'(dir));
    check_eq({tag, "/to"},     32'(to_port),     32'(tp));
    check_eq({tag, "/strobe"}, 32'(port_strobe), 32'(stb));
    check_eq({tag, "/busy"},   32'(busy),        32'(bsy));
    check_eq({tag, "/ready"},  32'(req_ready),   32'(!bsy));
  endtask

  // One full transaction starting in an IDLE cycle; ends in the cycle after HOLD.
  task automatic do_txn(input string tag, input logic wr, input logic [7:0] d,
                        input bit turn, input bit keep, input logic [7:0] last_rd);
    logic [7:0] drv;
    drv = wr ? d : 8'h00;
    check_eq({tag, "/accept_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_data  = d;
    tick();
    if (keep) req_data = 8'hEE;
    else      req_valid = 1'b0;
    from_port = 8'hC3;
    if (turn) begin
      for (int i = 0; i < 2; i++) begin
        expect_cycle({tag, "/turn"}, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
      end
    end
    for (int i = 0; i < 2; i++) begin
      expect_cycle({tag, "/setup"}, wr, drv, 1'b0, 1'b1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      from_port = (i == 3) ? last_rd : ((i % 2 == 0) ? 8'hFF : 8'h00);
      expect_cycle({tag, "/strobe"}, wr, drv, 1'b1, 1'b1);
      tick();
    end
    from_port = 8'h99;
    expect_cycle({tag, "/hold"}, wr, drv, 1'b0, 1'b1);
    tick();
    if (wr) begin
      expect_cycle({tag, "/park"}, 1'b1, d, 1'b0, 1'b0);
      check_eq({tag, "/no_rsp"}, 32'(rsp_valid), 32'd0);
    end else begin
      check_eq({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "/rsp_data"},  32'(rsp_data),  32'(last_rd));
      check_eq({tag, "/rsp_busy"},  32'(busy),      32'd1);
      check_eq({tag, "/rsp_dir"},   32'(dir_to_port), 32'd0);
    end
  endtask

  task automatic finish_read(input string tag, input int delay, input logic [7:0] exp);
    rsp_ready = 1'b0;
    for (int k = 0; k < delay; k++) begin
      check_eq({tag, "/bp_valid"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "/bp_data"},  32'(rsp_data),  32'(exp));
      check_eq({tag, "/bp_ready"}, 32'(req_ready), 32'd0);
      check_eq({tag, "/bp_busy"},  32'(busy),      32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    check_eq({tag, "/hs_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "/hs_data"},  32'(rsp_data),  32'(exp));
    tick();
    rsp_ready = 1'b0;
    check_eq({tag, "/done_valid"}, 32'(rsp_valid), 32'd0);
    expect_cycle({tag, "/park"}, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_data  = 8'h00;
    rsp_ready = 1'b0;
    from_port = 8'h00;
    #1;
    expect_cycle("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset/rsp_data",  32'(rsp_data),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();
    expect_cycle("post_reset", 1'b0, 8'h00, 1'b0, 1'b0);

    do_txn("wr_a5", 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00);
    tick();
    expect_cycle("wr_a5/park2", 1'b1, 8'hA5, 1'b0, 1'b0);

    do_txn("rd_3c", 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C);
    finish_read("rd_3c", 0, 8'h3C);

    do_txn("b2b_11", 1'b1, 8'h11, 1'b1, 1'b1, 8'h00);
    do_txn("b2b_22", 1'b1, 8'h22, 1'b0, 1'b1, 8'h00);
    do_txn("b2b_33", 1'b1, 8'h33, 1'b0, 1'b0, 8'h00);

    do_txn("rd_5a", 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A);
    finish_read("rd_5a", 5, 8'h5A);

    do_txn("wr_77", 1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_data  = 8'h88;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_cycle("wr_88/setup", 1'b1, 8'h88, 1'b0, 1'b1);
      tick();
    end
    tick();
    expect_cycle("wr_88/strobe", 1'b1, 8'h88, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    expect_cycle("async_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("async_reset/rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    check_eq("in_reset/rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk) reset = 1'b0;
    tick();
    check_eq("after_reset/rsp_valid", 32'(rsp_valid), 32'd0);
    expect_cycle("after_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    do_txn("wr_99", 1'b1, 8'h99, 1'b1, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
